div_issue: RTL

Issue and writeback front end for the 32x32 iterative divider. It accepts divide/remainder micro-ops tagged with a ROB tag from dispatch into a small in-order queue and drives the divider's `req/op/op1/op2` request side one operation at a time. It consumes the divider's `done/result` and returns the result on a writeback port, applying writeback backpressure to the divider through its `stall` input. It sits between the dispatch stage and the divider instance, on the initiator side of the divider handshake.

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_issue_fifo.sv | 71 +++++++
 rtl/div_issue.sv | 109 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue front end.
package div_pkg;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    localparam int unsigned DIV_LATENCY = 33;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } issue_state_t;

    // The ROB tag is stored beside this struct because its width is a module parameter.
    typedef struct packed {
        div_op_t     op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        killed;
    } divq_entry_t;

endpackage

// File: rtl/div_issue_fifo.sv
// In-order tagged circular buffer feeding the divider; supports drop-all and
// kill-all-but-head flushes.
module div_issue_fifo
    import div_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  divq_entry_t                push_entry,
    input  logic [TAG_W-1:0]           push_tag,
    input  logic                       pop,
    input  logic                       flush_keep,
    input  logic                       flush_drop,
    output divq_entry_t                head,
    output logic [TAG_W-1:0]           head_tag,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ready
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    divq_entry_t      mem  [DEPTH];
    logic [TAG_W-1:0] tags [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    assign head     = mem[rd_ptr];
    assign head_tag = tags[rd_ptr];
    assign ready    = (count != CNT_FULL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_drop) begin
            wr_ptr <= rd_ptr;
            count  <= '0;
        end else if (flush_keep) begin
            wr_ptr <= rd_ptr + PTR_ONE;
            count  <= CNT_ONE;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: an entry is only observed after a push rewrites it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]  <= push_entry;
            tags[wr_ptr] <= push_tag;
        end
        if (flush_keep)
            mem[rd_ptr].killed <= 1'b1;
    end

endmodule

// File: rtl/div_issue.sv
// Issue/writeback front end for the 32x32 iterative divider.
// Optional DIV_ISSUE_BYPASS_EN: an op arriving at an empty idle queue issues in the same cycle.
module div_issue
    import div_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_op1,
    input  logic [31:0]      in_op2,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             div_req,
    output logic [1:0]       div_op,
    output logic [31:0]      div_op1,
    output logic [31:0]      div_op2,
    input  logic             div_done,
    input  logic [31:0]      div_result,
    output logic             div_stall,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_tag,
    output logic [31:0]      wb_value,
    input  logic             wb_grant
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    issue_state_t     state;
    divq_entry_t      head;
    divq_entry_t      push_entry;
    logic [TAG_W-1:0] head_tag;
    logic [CNT_W-1:0] q_count;
    logic             q_empty;
    logic             accept;
    logic             busy;
    logic             issue;
    logic             keep_head;
    logic             done_live;
    logic             pop;
    logic             flush_keep;
    logic             flush_drop;

    assign busy       = (state == S_BUSY);
    assign q_empty    = (q_count == '0);
    assign accept     = in_valid & in_ready & ~flush;
    assign push_entry = '{op: div_op_t'(in_op), op1: in_op1, op2: in_op2, killed: 1'b0};

`ifdef DIV_ISSUE_BYPASS_EN
    logic bypass;
    assign bypass  = ~busy & q_empty & accept;
    assign issue   = ~busy & (~q_empty | bypass);
    assign div_op  = bypass ? in_op  : head.op;
    assign div_op1 = bypass ? in_op1 : head.op1;
    assign div_op2 = bypass ? in_op2 : head.op2;
`else
    assign issue   = ~busy & ~q_empty;
    assign div_op  = head.op;
    assign div_op1 = head.op1;
    assign div_op2 = head.op2;
`endif

    assign div_req   = issue;
    // A killed or flushed head drains silently, so it never stalls the divider.
    assign done_live = busy & div_done & ~head.killed & ~flush;
    assign wb_valid  = done_live;
    assign div_stall = done_live & ~wb_grant;
    assign pop       = busy & div_done & ~div_stall;
    assign wb_tag    = head_tag;
    assign wb_value  = div_result;

    assign keep_head  = busy | issue;
    assign flush_drop = flush & (pop | ~keep_head);
    assign flush_keep = flush & keep_head & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (issue) state <= S_BUSY;
                S_BUSY:  if (pop)   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    div_issue_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_entry (push_entry),
        .push_tag   (in_tag),
        .pop        (pop),
        .flush_keep (flush_keep),
        .flush_drop (flush_drop),
        .head       (head),
        .head_tag   (head_tag),
        .count      (q_count),
        .ready      (in_ready)
    );

endmodule
